// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
// Command/reply codes and FSM state encodings.
package loader_pkg;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] CMD_H   = 8'h48;
  localparam logic [7:0] CMD_G   = 8'h47;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    RESP,
    WAIT_TX
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_loader_if.sv
// Memory port bundle between the loader and instruction/data memory.
// The loader drives address/write side; memory returns read data.
interface uart_loader_if;

  logic [7:0] mem_addr;
  logic [7:0] mem_w_data;
  logic       mem_w_en;
  logic [7:0] mem_r_data;

  modport master (
    output mem_addr,
    output mem_w_data,
    output mem_w_en,
    input  mem_r_data
  );

  modport slave (
    input  mem_addr,
    input  mem_w_data,
    input  mem_w_en,
    output mem_r_data
  );

endinterface

// File: rtl/loader_rx.sv
// 8N1 receiver: synchronizer, start re-check, centre sampling.
// Emits a one-cycle rx_valid with rx_byte on a good stop bit.
module loader_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t      state;
  logic [2:0]     sync;
  logic [W-1:0]   cnt;
  logic [2:0]     bitn;
  logic [7:0]     sh;

  // sync[1] is the synchronized line, sync[2] its previous value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RX_IDLE;
      sync     <= 3'b111;
      cnt      <= '0;
      bitn     <= '0;
      sh       <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      sync     <= {sync[1:0], rx};
      rx_valid <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (sync[2] && !sync[1]) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            sh   <= {sync[1], sh[7:1]};
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync[1]) begin
              rx_valid <= 1'b1;
              rx_byte  <= sh;
            end
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART command responder that reads/writes memory and holds the CPU.
// Optional inter-byte timeout when LOADER_TIMEOUT_EN is defined.
module uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic tx,
  output logic cpu_hold,
  uart_loader_if.master mem
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  state_t       state;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic [7:0]   cmd;
  logic [7:0]   resp;
  logic [8:0]   tx_sh;
  logic [W-1:0] tx_cnt;
  logic [3:0]   tx_bit;
  logic         tx_busy;
  logic         tx_done;

`ifdef LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST =
    32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [31:0] to_cnt;
`endif

  loader_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte)
  );

  assign tx_done = tx_busy && tx_bit == 4'd9 && tx_cnt == LAST;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cmd            <= '0;
      resp           <= '0;
      cpu_hold       <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_w_data <= '0;
      mem.mem_w_en   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      to_cnt         <= '0;
`endif
    end else begin
      mem.mem_w_en <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      if (rx_valid || !(state == GET_ADDR || state == GET_DATA))
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 32'd1;
`endif
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd <= rx_byte;
            unique case (1'b1)
              rx_byte == CMD_W,
              rx_byte == CMD_R: state <= GET_ADDR;
              rx_byte == CMD_H: begin
                cpu_hold <= 1'b1;
                resp     <= RSP_ACK;
                state    <= RESP;
              end
              rx_byte == CMD_G: begin
                cpu_hold <= 1'b0;
                resp     <= RSP_ACK;
                state    <= RESP;
              end
              default: begin
                resp  <= RSP_NAK;
                state <= RESP;
              end
            endcase
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            mem.mem_addr <= rx_byte;
            state <= (cmd == CMD_W) ? GET_DATA : READ;
          end
`ifdef LOADER_TIMEOUT_EN
          else if (to_cnt == TO_LAST) state <= IDLE;
`endif
        end
        GET_DATA: begin
          if (rx_valid) begin
            mem.mem_w_data <= rx_byte;
            mem.mem_w_en   <= 1'b1;
            state          <= WRITE;
          end
`ifdef LOADER_TIMEOUT_EN
          else if (to_cnt == TO_LAST) state <= IDLE;
`endif
        end
        WRITE: begin
          resp  <= RSP_ACK;
          state <= RESP;
        end
        READ: begin
          resp  <= mem.mem_r_data;
          state <= RESP;
        end
        RESP:    state <= WAIT_TX;
        WAIT_TX: if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // tx_sh holds data bits then the stop bit; start bit is driven on load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx      <= 1'b1;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_busy <= 1'b0;
    end else if (state == RESP) begin
      tx      <= 1'b0;
      tx_sh   <= {1'b1, resp};
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized self-checking bench for uart_loader with a memory model.
// Expected replies come from a simple command-level reference model.
module tb_uart_loader;

  localparam int CPB = 16;
  localparam int TOB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic tx;
  logic cpu_hold;

  uart_loader_if mem ();

  logic [7:0] ram     [256];
  logic [7:0] exp_mem [256];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0]  rep_q[$];
  int          rep_cyc_q[$];
  logic [15:0] wq[$];
  int          wen_cyc  = 0;
  int          wen_long = 0;
  logic        wen_prev = 1'b0;

  assign mem.mem_r_data = ram[mem.mem_addr];

  always @(posedge clock)
    if (mem.mem_w_en === 1'b1) ram[mem.mem_addr] <= mem.mem_w_data;

  uart_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .tx       (tx),
    .cpu_hold (cpu_hold),
    .mem      (mem)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (mem.mem_w_en === 1'b1) begin
      wq.push_back({mem.mem_addr, mem.mem_w_data});
      wen_cyc = cyc;
      if (wen_prev) wen_long++;
    end
    wen_prev = (mem.mem_w_en === 1'b1);
  end

  // Serial decoder for replies on tx
  initial begin
    logic [7:0] b;
    int         c;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && tx === 1'b0) begin
        c = cyc;
        b = '0;
        repeat (CPB / 2 - 1) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b = {tx, b[7:1]};
        end
        repeat (CPB) @(negedge clock);
        rep_q.push_back({tx, b});
        rep_cyc_q.push_back(c);
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic wait_reply(output logic [8:0] r, output int c);
    r = 'x;
    c = -1;
    for (int i = 0; i < 40 * CPB; i++) begin
      if (rep_q.size() > 0) begin
        r = rep_q.pop_front();
        c = rep_cyc_q.pop_front();
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx got=%b exp=1", tx);
    end
    checks++;
    if (cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=0", cpu_hold);
    end
    checks++;
    if (mem.mem_w_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_wen got=%b exp=0", mem.mem_w_en);
    end
    checks++;
    if (mem.mem_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=00", mem.mem_addr);
    end
    checks++;
    if (mem.mem_w_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_wdata got=%h exp=00", mem.mem_w_data);
    end
  endtask

  task automatic test_hold;
    logic [8:0] r;
    int         c;
    send_byte(8'h48, 1'b1);
    wait_reply(r, c);
    checks++;
    if (r !== 9'h106) begin
      failures++;
      $display("FAIL hold_ack got=%h exp=106", r);
    end
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL hold_set got=%b exp=1", cpu_hold);
    end
    send_byte(8'h47, 1'b1);
    wait_reply(r, c);
    checks++;
    if (r !== 9'h106) begin
      failures++;
      $display("FAIL go_ack got=%h exp=106", r);
    end
    checks++;
    if (cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL hold_clr got=%b exp=0", cpu_hold);
    end
  endtask

  task automatic test_read;
    logic [8:0] r;
    int         c;
    logic [7:0] a;
    wq.delete();
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 8'hFF : 8'($urandom);
      send_byte(8'h52, 1'b1);
      send_byte(a, 1'b1);
      wait_reply(r, c);
      checks++;
      if (r !== {1'b1, exp_mem[a]}) begin
        failures++;
        $display("FAIL read_%h got=%h exp=%h", a, r, {1'b1, exp_mem[a]});
      end
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("FAIL read_nowrite got=%0d exp=0", wq.size());
    end
  endtask

  task automatic test_write;
    logic [8:0] r;
    int         c;
    logic [7:0] a;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      wq.delete();
      send_byte(8'h57, 1'b1);
      send_byte(a, 1'b1);
      send_byte(d, 1'b1);
      wait_reply(r, c);
      exp_mem[a] = d;
      checks++;
      if (r !== 9'h106) begin
        failures++;
        $display("FAIL write_ack got=%h exp=106", r);
      end
      checks++;
      if (wq.size() != 1 || wq[0] !== {a, d}) begin
        failures++;
        $display("FAIL write_port n=%0d got=%h exp=%h",
                 wq.size(), (wq.size() > 0) ? wq[0] : 16'hxxxx, {a, d});
      end
      checks++;
      if (c - wen_cyc != 2) begin
        failures++;
        $display("FAIL write_lat got=%0d exp=2", c - wen_cyc);
      end
    end
    checks++;
    if (wen_long != 0) begin
      failures++;
      $display("FAIL wen_pulse got=%0d exp=0", wen_long);
    end
    send_byte(8'h52, 1'b1);
    send_byte(a, 1'b1);
    wait_reply(r, c);
    checks++;
    if (r !== {1'b1, exp_mem[a]}) begin
      failures++;
      $display("FAIL write_rb got=%h exp=%h", r, {1'b1, exp_mem[a]});
    end
  endtask

  task automatic test_nak;
    logic [8:0] r;
    int         c;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        b = 8'h00;
      end else begin
        do b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52 || b == 8'h48 || b == 8'h47);
      end
      send_byte(b, 1'b1);
      wait_reply(r, c);
      checks++;
      if (r !== 9'h115) begin
        failures++;
        $display("FAIL nak_%h got=%h exp=115", b, r);
      end
    end
  endtask

  task automatic test_framing;
    logic [8:0] r;
    int         c;
    send_byte(8'h48, 1'b0);
    idle_bits(25);
    checks++;
    if (rep_q.size() != 0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL framing got=%0d/%b exp=0/0", rep_q.size(), cpu_hold);
    end
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    idle_bits(25);
    checks++;
    if (rep_q.size() != 0) begin
      failures++;
      $display("FAIL glitch got=%0d exp=0", rep_q.size());
    end
    send_byte(8'h47, 1'b1);
    wait_reply(r, c);
    checks++;
    if (r !== 9'h106) begin
      failures++;
      $display("FAIL post_err_ack got=%h exp=106", r);
    end
  endtask

  task automatic test_timeout;
    logic [8:0] r;
    int         c;
    wq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h20, 1'b1);
    idle_bits(5);
    send_byte(8'h52, 1'b1);
`ifdef LOADER_TIMEOUT_EN
    send_byte(8'h20, 1'b1);
    wait_reply(r, c);
    checks++;
    if (r !== {1'b1, exp_mem[8'h20]}) begin
      failures++;
      $display("FAIL to_read got=%h exp=%h", r, {1'b1, exp_mem[8'h20]});
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("FAIL to_nowrite got=%0d exp=0", wq.size());
    end
`else
    wait_reply(r, c);
    exp_mem[8'h20] = 8'h52;
    checks++;
    if (r !== 9'h106) begin
      failures++;
      $display("FAIL nto_ack got=%h exp=106", r);
    end
    checks++;
    if (wq.size() != 1 || wq[0] !== 16'h2052) begin
      failures++;
      $display("FAIL nto_write n=%0d exp=2052", wq.size());
    end
    send_byte(8'h52, 1'b1);
    send_byte(8'h20, 1'b1);
    wait_reply(r, c);
    checks++;
    if (r !== 9'h152) begin
      failures++;
      $display("FAIL nto_rb got=%h exp=152", r);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic [8:0] r;
    int         c;
    logic [7:0] d;
    d = 8'($urandom);
    send_byte(8'h48, 1'b1);
    wait_reply(r, c);
    wq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'($urandom), 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset tx=%b hold=%b exp=1/0", tx, cpu_hold);
    end
    repeat (3) @(negedge clock);
    rx = 1'b1;
    reset = 1'b0;
    idle_bits(30);
    checks++;
    if (wq.size() != 0 || rep_q.size() != 0) begin
      failures++;
      $display("FAIL mid_quiet got=%0d/%0d exp=0/0", wq.size(), rep_q.size());
    end
    rep_q.delete();
    rep_cyc_q.delete();
    send_byte(8'h48, 1'b1);
    wait_reply(r, c);
    checks++;
    if (r !== 9'h106 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL mid_hold got=%h/%b exp=106/1", r, cpu_hold);
    end
    send_byte(8'h47, 1'b1);
    wait_reply(r, c);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    ram[255]     = 8'h3C;
    exp_mem[255] = 8'h3C;
    @(negedge clock);
    test_reset();
    test_hold();
    test_read();
    test_write();
    test_nak();
    test_framing();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Serial responder on the host side of the UART link: receives 8N1 command frames on `rx`, performs byte reads/writes on an 8-bit-address memory port (instruction or data memory), and answers on `tx`. Lets a PC load programs and inspect memory over the same serial line the CPU's memory-mapped UART uses. It also holds the CPU while a load is in progress. Sits beside `cpu` in the top level and muxes onto the memory write port when `cpu_hold` is high.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit; must be ≥ 4.
- `TIMEOUT_BITS`, 64, inter-byte timeout in bit periods; used only with `LOADER_TIMEOUT_EN`.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial in, idle high, asynchronous to `clock`.
- `tx`  out  1  serial out, idle high.
- `mem_addr`  out  8  memory address.
- `mem_w_data`  out  8  write data.
- `mem_w_en`  out  1  one-cycle write strobe.
- `mem_r_data`  in  8  read data; valid one cycle after `mem_addr` changes.
- `cpu_hold`  out  1  high = CPU stalled; the loader owns the memory port.

## Operation
- Frames: 8N1, LSB first.
- RX path:
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked at `CLKS_PER_BIT/2`; if `rx` is high there, the frame is a glitch and is ignored.
  - Data bits are sampled at bit centres.
  - Stop bit = 0 is a framing error: the byte is discarded and the FSM is unaffected.
- Commands:
  - 0x57 'W', addr, data: write `data` to `addr`, reply 0x06.
  - 0x52 'R', addr: reply `mem[addr]`.
  - 0x48 'H': set `cpu_hold`, reply 0x06.
  - 0x47 'G': clear `cpu_hold`, reply 0x06.
  - Any other first byte: reply 0x15, return to IDLE.
- 'W' and 'R' are accepted whether or not `cpu_hold` is set. The host is responsible for issuing 'H' first.
- FSM states: IDLE, GET_ADDR, GET_DATA, WRITE, READ, RESP, WAIT_TX.
  - IDLE → GET_ADDR on 'W'/'R'; → RESP on 'H'/'G'/unknown.
  - GET_ADDR → GET_DATA ('W') or READ ('R').
  - GET_DATA → WRITE.
  - WRITE → RESP; READ → RESP.
  - RESP loads the TX shifter → WAIT_TX.
  - WAIT_TX → IDLE when the stop bit completes.
- Bytes completing while in RESP or WAIT_TX are dropped. The protocol is strictly request/response.
- `mem_addr` and `mem_w_data` hold their last values between commands.

## Timing
- Reset values: `tx`=1, `cpu_hold`=0, `mem_w_en`=0, `mem_addr`=0x00, `mem_w_data`=0x00; FSM in IDLE; RX and TX idle.
- A byte is "received" in the cycle its stop bit is sampled high.
- `mem_addr` is updated the cycle after the addr byte is received.
- Write:
  - `mem_w_data` is updated the cycle after the data byte is received.
  - `mem_w_en` is high for exactly the following cycle (WRITE state).
  - The reply start bit begins 2 cycles after WRITE.
- Read: READ lasts 1 cycle and samples `mem_r_data` at its end. The reply start bit begins 2 cycles after READ.
- `cpu_hold` changes in the RESP cycle of 'H'/'G', i.e. before the ACK starts.
- TX bit length is exactly `CLKS_PER_BIT` cycles. Frame length is 10 × `CLKS_PER_BIT`.
- `reset` asserted mid-frame or mid-command:
  - all state returns to reset values immediately;
  - `tx` goes high;
  - a partial TX frame is truncated with no error indication;
  - `cpu_hold` is released.
- Back-to-back RX frames (stop bit immediately followed by start) are received without loss.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - In GET_ADDR/GET_DATA, a counter reloads on every received byte.
  - If `TIMEOUT_BITS × CLKS_PER_BIT` cycles pass with no byte, the FSM returns to IDLE.
  - No reply is sent and no write occurs.
- `LOADER_TIMEOUT_EN` undefined:
  - There is no counter and a partial command waits indefinitely.
  - Only `reset` aborts a partial command.

## Structure
- Shared package `loader_pkg` holds:
  - command and reply codes: `CMD_W`=0x57, `CMD_R`=0x52, `CMD_H`=0x48, `CMD_G`=0x47, `RSP_ACK`=0x06, `RSP_NAK`=0x15;
  - the FSM state enum.
- One sub-module, `loader_rx`: synchronizer, start check, bit sampling, and a `rx_valid` pulse with `rx_byte`.
- The TX shifter and the FSM live in `uart_loader`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, `TIMEOUT_BITS`=4.
- Send 0x48 → `cpu_hold` rises, `tx` returns 0x06. Send 0x47 → `cpu_hold` falls, `tx` returns 0x06.
- Send 0x57,0x10,0xA5 → a single-cycle `mem_w_en` with `mem_addr`=0x10 and `mem_w_data`=0xA5, then `tx` returns 0x06.
- Memory model with mem[0xFF]=0x3C; send 0x52,0xFF → `tx` returns 0x3C and no `mem_w_en` occurs.
- Send 0x00 → `tx` returns 0x15. Send a frame with stop=0 → nothing is sent. Send a 0.3-bit low glitch → nothing is sent.
- Send 0x57,0x20, then idle 5 bit periods, then 0x52,0x20:
  - with `LOADER_TIMEOUT_EN`: no write occurs and the read is answered;
  - without it: the 0x52 is taken as the data byte, so mem[0x20]=0x52 and `tx` returns 0x06.
- Assert `reset` midway through the 'W' data byte → `tx`=1, `cpu_hold`=0, no write occurs, and the next 'H' is ACKed normally.
